frc_bus_sched: RTL and testbench

- Sequences force/release operations onto an N-bit signal array. The array's output per bit is mask[i] ? val[i] : live[i].
- Shares the force resource between two requesters (A, B) using round-robin arbitration.
- Holds a per-bit force mask and force value, and signals completion after a settle window.
- Sits between testbench/emulation control agents and the force-mux datapath of the array.

---
 rtl/frc_bus_sched_pkg.sv | 22 ++
 rtl/frc_bus_sched_if.sv | 23 ++
 rtl/frc_bus_sched_arb.sv | 28 ++
 rtl/frc_bus_sched.sv | 185 ++++++++++++++++++
 tb/tb_frc_bus_sched.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frc_bus_sched_pkg.sv
// Shared types for the force/release bus scheduler.
// Op codes, FSM states and requester source encodings.
package frc_sched_pkg;

  typedef enum logic [1:0] {
    FRC_NOP         = 2'b00,
    FRC_FORCE       = 2'b01,
    FRC_RELEASE     = 2'b10,
    FRC_RELEASE_ALL = 2'b11
  } frc_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    APPLY  = 2'b01,
    SETTLE = 2'b10,
    DONE   = 2'b11
  } frc_state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/frc_bus_sched_if.sv
// Requester op channel: valid/ready handshake with op, bit index and value.
// The agent side uses master, the scheduler uses slave.
interface frc_bus_sched_if #(
  parameter int WIDTH = 8
) ();
  localparam int IW = $clog2(WIDTH);

  logic          valid;
  logic          ready;
  logic [1:0]    op;
  logic [IW-1:0] idx;
  logic          val;

  modport master (
    output valid, op, idx, val,
    input  ready
  );

  modport slave (
    input  valid, op, idx, val,
    output ready
  );
endinterface

// File: rtl/frc_bus_sched_arb.sv
// Two-way round-robin arbiter; the last-grant register starts
// as if B was served, so A is favoured out of reset.
module frc_rr_arb2
  import frc_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic r_last;

  always_comb begin
    gnt = req;
    if (req == 2'b11)
      gnt = r_last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_last <= SRC_B;
    else if (advance)
      r_last <= gnt[1];
  end

endmodule

// File: rtl/frc_bus_sched.sv
// Force/release scheduler for an N-bit forceable signal array.
// Define FRC_WDOG_EN to add the idle watchdog auto-release.
module frc_bus_sched
  import frc_sched_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SETTLE_CYC = 2,
  parameter int TIMEOUT    = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  frc_bus_sched_if.slave         a_if,
  frc_bus_sched_if.slave         b_if,
  output logic [WIDTH-1:0]       force_mask,
  output logic [WIDTH-1:0]       force_val,
  output logic                   done,
  output logic                   done_src,
  output logic [$clog2(WIDTH):0] forced_cnt,
  output logic                   err,
  output logic                   wdog_fire
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = IW + 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam bit HAS_OOB = (1 << IW) > WIDTH;

  frc_state_e       r_state, w_next;
  frc_op_e          r_op;
  logic [IW-1:0]    r_idx;
  logic             r_val;
  logic             r_src;
  logic [SW-1:0]    r_settle;
  logic [WIDTH-1:0] r_mask, r_vreg;
  logic [CW-1:0]    r_cnt;
  logic             r_err;

  logic [1:0]       w_req, w_gnt;
  logic             w_xfer, w_oob, w_fire, w_upd, w_set_err;
  logic [1:0]       w_in_op;
  logic [IW-1:0]    w_in_idx;
  logic             w_in_val;
  logic [WIDTH-1:0] w_mask_nxt, w_vreg_nxt;
  logic [CW-1:0]    w_pop;

  assign w_req  = {b_if.valid, a_if.valid};
  assign w_xfer = (r_state == IDLE) && (|w_req);

  frc_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (w_req),
    .advance (w_xfer),
    .gnt     (w_gnt)
  );

  assign a_if.ready = (r_state == IDLE) && w_gnt[0];
  assign b_if.ready = (r_state == IDLE) && w_gnt[1];

  assign w_in_op  = w_gnt[1] ? b_if.op  : a_if.op;
  assign w_in_idx = w_gnt[1] ? b_if.idx : a_if.idx;
  assign w_in_val = w_gnt[1] ? b_if.val : a_if.val;

  // Index can only exceed the array when WIDTH is not a power of two.
  if (HAS_OOB) begin : g_oob
    assign w_oob = ({1'b0, r_idx} >= CW'(WIDTH));
  end else begin : g_no_oob
    assign w_oob = 1'b0;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (w_xfer) w_next = APPLY;
      APPLY:  w_next = SETTLE;
      SETTLE: if (r_settle == '0) w_next = DONE;
      DONE:   w_next = IDLE;
    endcase
  end

  always_comb begin
    w_mask_nxt = r_mask;
    w_vreg_nxt = r_vreg;
    w_set_err  = 1'b0;
    if (w_fire) begin
      w_mask_nxt = '0;
    end else if (r_state == APPLY) begin
      unique case (r_op)
        FRC_NOP: ;
        FRC_FORCE: begin
          w_set_err = w_oob;
          if (!w_oob) begin
            w_mask_nxt[r_idx] = 1'b1;
            w_vreg_nxt[r_idx] = r_val;
          end
        end
        FRC_RELEASE: begin
          w_set_err = w_oob;
          if (!w_oob) w_mask_nxt[r_idx] = 1'b0;
        end
        FRC_RELEASE_ALL: w_mask_nxt = '0;
      endcase
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++)
      w_pop = w_pop + CW'(w_mask_nxt[i]);
  end

  assign w_upd = w_fire || (r_state == APPLY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_op     <= FRC_NOP;
      r_idx    <= '0;
      r_val    <= 1'b0;
      r_src    <= SRC_A;
      r_settle <= '0;
      r_mask   <= '0;
      r_vreg   <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_xfer) begin
        r_op  <= frc_op_e'(w_in_op);
        r_idx <= w_in_idx;
        r_val <= w_in_val;
        r_src <= w_gnt[1] ? SRC_B : SRC_A;
      end
      if (r_state == APPLY)
        r_settle <= SW'(SETTLE_CYC - 1);
      else if (r_state == SETTLE && r_settle != '0)
        r_settle <= r_settle - 1'b1;
      if (w_upd) begin
        r_mask <= w_mask_nxt;
        r_vreg <= w_vreg_nxt;
        r_cnt  <= w_pop;
      end
      if (w_set_err)
        r_err <= 1'b1;
    end
  end

`ifdef FRC_WDOG_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] r_idle;
  logic          r_wdog;
  logic          w_idle;

  // A pending request blocks the count, so a transfer always wins.
  assign w_idle = (r_state == IDLE) && !(|w_req) && (|r_mask);
  assign w_fire = w_idle && (r_idle == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idle <= '0;
      r_wdog <= 1'b0;
    end else begin
      r_wdog <= w_fire;
      if (w_idle && !w_fire)
        r_idle <= r_idle + 1'b1;
      else
        r_idle <= '0;
    end
  end

  assign wdog_fire = r_wdog;
`else
  assign w_fire    = 1'b0;
  assign wdog_fire = 1'b0;
`endif

  assign force_mask = r_mask;
  assign force_val  = r_vreg;
  assign forced_cnt = r_cnt;
  assign err        = r_err;
  assign done       = (r_state == DONE);
  assign done_src   = (r_state == DONE) && r_src;

endmodule

// File: tb/tb_frc_bus_sched.sv
// Directed bench for frc_bus_sched: an 8-bit and a 6-bit instance.
// Watchdog scenarios run when FRC_WDOG_EN is defined.
module tb_frc_bus_sched;
  import frc_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int wd_seen = 0;
  int cyc = 0;

  frc_bus_sched_if #(.WIDTH(8)) m_a ();
  frc_bus_sched_if #(.WIDTH(8)) m_b ();
  frc_bus_sched_if #(.WIDTH(6)) s_a ();
  frc_bus_sched_if #(.WIDTH(6)) s_b ();

  logic [7:0] mask, fval;
  logic [3:0] cnt;
  logic       done, dsrc, err, wdog;
  logic [5:0] s_mask, s_fval;
  logic [3:0] s_cnt;
  logic       s_done, s_dsrc, s_err, s_wdog;

  frc_bus_sched #(.WIDTH(8), .SETTLE_CYC(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .a_if(m_a), .b_if(m_b),
    .force_mask(mask), .force_val(fval), .done(done),
    .done_src(dsrc), .forced_cnt(cnt), .err(err),
    .wdog_fire(wdog)
  );

  frc_bus_sched #(.WIDTH(6), .SETTLE_CYC(2), .TIMEOUT(16)) dut6 (
    .clk(clk), .rst_n(rst_n), .a_if(s_a), .b_if(s_b),
    .force_mask(s_mask), .force_val(s_fval), .done(s_done),
    .done_src(s_dsrc), .forced_cnt(s_cnt), .err(s_err),
    .wdog_fire(s_wdog)
  );

  always @(posedge clk) cyc++;
  always @(negedge clk) if (wdog) wd_seen++;

  initial begin
    #300000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1);
  end

  task automatic clear_inputs();
    m_a.valid = 0; m_a.op = 0; m_a.idx = 0; m_a.val = 0;
    m_b.valid = 0; m_b.op = 0; m_b.idx = 0; m_b.val = 0;
    s_a.valid = 0; s_a.op = 0; s_a.idx = 0; s_a.val = 0;
    s_b.valid = 0; s_b.op = 0; s_b.idx = 0; s_b.val = 0;
  endtask

  task automatic drive(input bit sel, input bit src,
                       input logic [1:0] op, input logic [2:0] idx,
                       input bit v);
    case ({sel, src})
      2'b00: begin m_a.valid = 1; m_a.op = op; m_a.idx = idx; m_a.val = v; end
      2'b01: begin m_b.valid = 1; m_b.op = op; m_b.idx = idx; m_b.val = v; end
      2'b10: begin s_a.valid = 1; s_a.op = op; s_a.idx = idx; s_a.val = v; end
      default: begin s_b.valid = 1; s_b.op = op; s_b.idx = idx; s_b.val = v; end
    endcase
  endtask

  task automatic undrive(input bit sel, input bit src);
    case ({sel, src})
      2'b00: m_a.valid = 0;
      2'b01: m_b.valid = 0;
      2'b10: s_a.valid = 0;
      default: s_b.valid = 0;
    endcase
  endtask

  function automatic bit rdy(input bit sel, input bit src);
    case ({sel, src})
      2'b00: return m_a.ready;
      2'b01: return m_b.ready;
      2'b10: return s_a.ready;
      default: return s_b.ready;
    endcase
  endfunction

  function automatic bit dn(input bit sel);
    return sel ? s_done : done;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // Bounded wait for done; k counts negedges from the call.
  task automatic wait_done(input bit sel, output int k);
    k = 0;
    while (!dn(sel) && k < 30) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Issue one op; lat is the transfer-to-done distance or -1.
  task automatic do_op(input bit sel, input bit src,
                       input logic [1:0] op, input logic [2:0] idx,
                       input bit v, output int lat, output bit srcd);
    int w, k;
    @(negedge clk);
    drive(sel, src, op, idx, v);
    #1;
    w = 0;
    while (!rdy(sel, src) && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (w >= 20) begin
      undrive(sel, src);
      lat = -1;
      srcd = 0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    undrive(sel, src);
    wait_done(sel, k);
    lat = (k >= 30) ? -1 : k + 1;
    srcd = sel ? s_dsrc : dsrc;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({mask, fval, cnt} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got %h/%h/%0d want 0/0/0", mask, fval, cnt);
    end
    n_chk++;
    if ({err, done, dsrc, wdog} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000", {err, done, dsrc, wdog});
    end
    n_chk++;
    if ({m_a.ready, m_b.ready, s_err, s_mask} !== 9'h0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 0", {m_a.ready, m_b.ready, s_err, s_mask});
    end
    rst_n = 1;
  endtask

  task automatic test_force_basic();
    do_reset();
    @(negedge clk);
    drive(0, 0, FRC_FORCE, 3'd3, 1);
    #1;
    n_chk++;
    if (m_a.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready: got %b want 1", m_a.ready);
    end
    @(posedge clk);
    @(negedge clk);
    undrive(0, 0);
    n_chk++;
    if (mask !== 8'h00) begin
      n_fail++;
      $display("FAIL basic_t1_mask: got %h want 00", mask);
    end
    @(negedge clk);
    n_chk++;
    if ({mask, fval[3], cnt} !== {8'h08, 1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL basic_t2: got mask %h v3 %b cnt %0d want 08 1 1", mask, fval[3], cnt);
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_t3_done: got %b want 0", done);
    end
    @(negedge clk);
    n_chk++;
    if ({done, dsrc} !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_t4_done: got %b want 10", {done, dsrc});
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_t5_done: got %b want 0", done);
    end
  endtask

  task automatic test_arb();
    int k;
    do_reset();
    @(negedge clk);
    drive(0, 0, FRC_FORCE, 3'd0, 0);
    drive(0, 1, FRC_FORCE, 3'd7, 1);
    #1;
    n_chk++;
    if ({m_a.ready, m_b.ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL arb_first: got %b want 10", {m_a.ready, m_b.ready});
    end
    @(posedge clk);
    @(negedge clk);
    undrive(0, 0);
    wait_done(0, k);
    n_chk++;
    if ({k, dsrc} !== {32'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL arb_done_a: got k %0d src %b want 3 0", k, dsrc);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if ({m_a.ready, m_b.ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL arb_second: got %b want 01", {m_a.ready, m_b.ready});
    end
    @(posedge clk);
    @(negedge clk);
    undrive(0, 1);
    wait_done(0, k);
    n_chk++;
    if ({k, dsrc} !== {32'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL arb_done_b: got k %0d src %b want 3 1", k, dsrc);
    end
    @(negedge clk);
    n_chk++;
    if ({mask, fval, cnt} !== {8'h81, 8'h80, 4'd2}) begin
      n_fail++;
      $display("FAIL arb_final: got %h %h %0d want 81 80 2", mask, fval, cnt);
    end
    drive(0, 0, FRC_NOP, 3'd0, 0);
    drive(0, 1, FRC_NOP, 3'd0, 0);
    #1;
    n_chk++;
    if ({m_a.ready, m_b.ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL arb_rr_back_to_a: got %b want 10", {m_a.ready, m_b.ready});
    end
    @(posedge clk);
    @(negedge clk);
    undrive(0, 0);
    undrive(0, 1);
    wait_done(0, k);
  endtask

  task automatic test_overwrite();
    int lat;
    bit s;
    do_reset();
    do_op(0, 0, FRC_FORCE, 3'd2, 1, lat, s);
    n_chk++;
    if ({lat, mask, cnt, fval[2]} !== {32'd4, 8'h04, 4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL ow_force1: got lat %0d %h %0d %b want 4 04 1 1", lat, mask, cnt, fval[2]);
    end
    do_op(0, 0, FRC_FORCE, 3'd2, 0, lat, s);
    n_chk++;
    if ({mask, cnt, fval[2]} !== {8'h04, 4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL ow_force2: got %h %0d %b want 04 1 0", mask, cnt, fval[2]);
    end
    do_op(0, 0, FRC_RELEASE, 3'd2, 1, lat, s);
    n_chk++;
    if ({mask, cnt, fval[2]} !== {8'h00, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL ow_release: got %h %0d %b want 00 0 0", mask, cnt, fval[2]);
    end
    do_op(0, 0, FRC_RELEASE, 3'd4, 0, lat, s);
    n_chk++;
    if ({lat, mask, err} !== {32'd4, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL ow_rel_unforced: got lat %0d %h err %b want 4 00 0", lat, mask, err);
    end
    do_op(0, 1, FRC_NOP, 3'd5, 1, lat, s);
    n_chk++;
    if ({lat, s, mask} !== {32'd4, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL ow_nop: got lat %0d src %b %h want 4 1 00", lat, s, mask);
    end
    do_op(0, 0, FRC_FORCE, 3'd1, 1, lat, s);
    do_op(0, 1, FRC_FORCE, 3'd6, 1, lat, s);
    n_chk++;
    if ({mask, cnt} !== {8'h42, 4'd2}) begin
      n_fail++;
      $display("FAIL ow_two_forced: got %h %0d want 42 2", mask, cnt);
    end
    do_op(0, 0, FRC_RELEASE_ALL, 3'd0, 0, lat, s);
    n_chk++;
    if ({mask, cnt, fval} !== {8'h00, 4'd0, 8'h42}) begin
      n_fail++;
      $display("FAIL ow_release_all: got %h %0d %h want 00 0 42", mask, cnt, fval);
    end
  endtask

  task automatic test_back_to_back();
    int w, k;
    int tx[3];
    do_reset();
    @(negedge clk);
    drive(0, 0, FRC_FORCE, 3'd0, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      w = 0;
      while (!m_a.ready && w < 20) begin
        @(negedge clk);
        #1;
        w++;
      end
      tx[i] = cyc;
      @(posedge clk);
      @(negedge clk);
      if (i == 2) undrive(0, 0);
      else drive(0, 0, FRC_FORCE, 3'(i + 1), 1);
    end
    n_chk++;
    if ({tx[1] - tx[0], tx[2] - tx[1]} !== {32'd5, 32'd5}) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d %0d want 5 5", tx[1] - tx[0], tx[2] - tx[1]);
    end
    wait_done(0, k);
    n_chk++;
    if ({mask, cnt} !== {8'h07, 4'd3}) begin
      n_fail++;
      $display("FAIL b2b_mask: got %h %0d want 07 3", mask, cnt);
    end
  endtask

  task automatic test_err();
    int lat;
    bit s;
    do_reset();
    do_op(1, 0, FRC_FORCE, 3'd5, 1, lat, s);
    n_chk++;
    if ({s_mask, s_err} !== {6'h20, 1'b0}) begin
      n_fail++;
      $display("FAIL err_inrange: got %h %b want 20 0", s_mask, s_err);
    end
    do_op(1, 1, FRC_FORCE, 3'd7, 1, lat, s);
    n_chk++;
    if ({lat, s, s_mask, s_cnt, s_err} !== {32'd4, 1'b1, 6'h20, 4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL err_oob: got lat %0d src %b %h %0d err %b want 4 1 20 1 1",
               lat, s, s_mask, s_cnt, s_err);
    end
    do_op(1, 0, FRC_FORCE, 3'd1, 0, lat, s);
    n_chk++;
    if ({s_mask, s_cnt, s_err, err} !== {6'h22, 4'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL err_sticky: got %h %0d %b main %b want 22 2 1 0", s_mask, s_cnt, s_err, err);
    end
  endtask

  task automatic test_reset_midop();
    int w, nd, lat;
    bit s;
    do_reset();
    @(negedge clk);
    drive(0, 0, FRC_FORCE, 3'd1, 1);
    #1;
    w = 0;
    while (!m_a.ready && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    @(posedge clk);
    @(negedge clk);
    undrive(0, 0);
    @(negedge clk);
    n_chk++;
    if (mask !== 8'h02) begin
      n_fail++;
      $display("FAIL mid_settle_mask: got %h want 02", mask);
    end
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    n_chk++;
    if ({mask, cnt, done} !== {8'h00, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_after_rst: got %h %0d %b want 00 0 0", mask, cnt, done);
    end
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) nd++;
    end
    n_chk++;
    if (nd !== 0) begin
      n_fail++;
      $display("FAIL mid_no_done: got %0d pulses want 0", nd);
    end
    do_op(0, 0, FRC_FORCE, 3'd4, 1, lat, s);
    n_chk++;
    if ({lat, mask, cnt} !== {32'd4, 8'h10, 4'd1}) begin
      n_fail++;
      $display("FAIL mid_next_op: got lat %0d %h %0d want 4 10 1", lat, mask, cnt);
    end
  endtask

`ifdef FRC_WDOG_EN
  task automatic test_wdog();
    int lat, k, base;
    bit s;
    do_reset();
    do_op(0, 0, FRC_FORCE, 3'd5, 1, lat, s);
    k = 0;
    while (!wdog && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if ({k, mask, cnt} !== {32'd17, 8'h00, 4'd0}) begin
      n_fail++;
      $display("FAIL wdog_fire: got k %0d %h %0d want 17 00 0", k, mask, cnt);
    end
    @(negedge clk);
    n_chk++;
    if (wdog !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_pulse_len: got %b want 0", wdog);
    end
    do_op(0, 0, FRC_FORCE, 3'd5, 1, lat, s);
    base = wd_seen;
    repeat (10) @(negedge clk);
    do_op(0, 1, FRC_NOP, 3'd0, 0, lat, s);
    n_chk++;
    if (wd_seen !== base) begin
      n_fail++;
      $display("FAIL wdog_nop_blocks: got %0d fires want 0", wd_seen - base);
    end
    k = 0;
    while (!wdog && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if ({k, mask} !== {32'd17, 8'h00}) begin
      n_fail++;
      $display("FAIL wdog_after_nop: got k %0d %h want 17 00", k, mask);
    end
  endtask
`else
  task automatic test_wdog();
    n_chk++;
    if ({wd_seen, wdog} !== {32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL wdog_off: got %0d fires want 0", wd_seen);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_force_basic();
    test_arb();
    test_overwrite();
    test_back_to_back();
    test_err();
    test_reset_midop();
    test_wdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
